// File: rtl/tiny_rv_rr_fwd_if.sv
// rtl/tiny_rv_rr_fwd_if.sv - signal bundle between decode, forwarding sources and the rr stage
interface tiny_rv_rr_fwd_if #(
  parameter int XLEN    = 32,
  parameter int NUM_FWD = 2,
  parameter int CNT_W   = 16
);
  logic                    i_pipe_stall;
  logic                    i_pipe_flush;
  logic                    decode_valid;
  logic [XLEN-1:0]         decode_pc;
  logic [31:0]             decode_inst;
  logic [XLEN-1:0]         decode_imm32;
  logic [6:0]              decode_opcode;
  logic [2:0]              decode_funct3;
  logic [6:0]              decode_funct7;
  logic [4:0]              decode_rs1;
  logic [4:0]              decode_rs2;
  logic [4:0]              decode_rd;
  logic [4:0]              read_p1;
  logic [4:0]              read_p2;
  logic [XLEN-1:0]         data_p1;
  logic [XLEN-1:0]         data_p2;
  logic [NUM_FWD-1:0]      fwd_valid;
  logic [NUM_FWD-1:0]      fwd_pending;
  logic [5*NUM_FWD-1:0]    fwd_reg;
  logic [XLEN*NUM_FWD-1:0] fwd_val;
  logic                    o_hazard_stall;
  logic [CNT_W-1:0]        o_hazard_cnt;
  logic                    rr_valid;
  logic [XLEN-1:0]         rr_pc;
  logic [31:0]             rr_inst;
  logic [XLEN-1:0]         rr_imm32;
  logic [6:0]              rr_opcode;
  logic [2:0]              rr_funct3;
  logic [6:0]              rr_funct7;
  logic [4:0]              rr_rd;
  logic [XLEN-1:0]         rr_rs1;
  logic [XLEN-1:0]         rr_rs2;

  modport master (
    output i_pipe_stall, i_pipe_flush, decode_valid, decode_pc, decode_inst, decode_imm32,
           decode_opcode, decode_funct3, decode_funct7, decode_rs1, decode_rs2, decode_rd,
           data_p1, data_p2, fwd_valid, fwd_pending, fwd_reg, fwd_val,
    input  read_p1, read_p2, o_hazard_stall, o_hazard_cnt, rr_valid, rr_pc, rr_inst,
           rr_imm32, rr_opcode, rr_funct3, rr_funct7, rr_rd, rr_rs1, rr_rs2
  );

  modport slave (
    input  i_pipe_stall, i_pipe_flush, decode_valid, decode_pc, decode_inst, decode_imm32,
           decode_opcode, decode_funct3, decode_funct7, decode_rs1, decode_rs2, decode_rd,
           data_p1, data_p2, fwd_valid, fwd_pending, fwd_reg, fwd_val,
    output read_p1, read_p2, o_hazard_stall, o_hazard_cnt, rr_valid, rr_pc, rr_inst,
           rr_imm32, rr_opcode, rr_funct3, rr_funct7, rr_rd, rr_rs1, rr_rs2
  );
endinterface

// File: rtl/tiny_rv_rr_fwd.sv
// rtl/tiny_rv_rr_fwd.sv - register-read stage with priority forwarding and load-use bubbles
module tiny_rv_rr_fwd #(
  parameter int XLEN    = 32,
  parameter int NUM_FWD = 2,
  parameter int CNT_W   = 16
) (
  input logic             i_clk,
  input logic             i_reset,
  tiny_rv_rr_fwd_if.slave bus
);
  localparam logic [6:0]  OPC_LUI    = 7'b0110111;
  localparam logic [6:0]  OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0]  OPC_JAL    = 7'b1101111;
  localparam logic [6:0]  OPC_OP     = 7'b0110011;
  localparam logic [6:0]  OPC_STORE  = 7'b0100011;
  localparam logic [6:0]  OPC_BRANCH = 7'b1100011;
  localparam logic [6:0]  OPC_NOP    = 7'h13;
  localparam logic [31:0] INST_NOP   = 32'h00000013;

  logic [XLEN-1:0] val1, val2;
  logic            pend1, pend2;
  logic            use1, use2;
  logic            hazard;
  logic            hazard_stall;

  assign bus.read_p1 = bus.decode_rs1;
  assign bus.read_p2 = bus.decode_rs2;

  // Resolve both operands: walk sources from lowest priority up so the youngest match wins last.
  always_comb begin
    val1  = bus.data_p1;
    val2  = bus.data_p2;
    pend1 = 1'b0;
    pend2 = 1'b0;
    for (int k = NUM_FWD - 1; k >= 0; k--) begin
      if (bus.fwd_valid[k] && (bus.fwd_reg[k*5 +: 5] != 5'd0)) begin
        if (bus.fwd_reg[k*5 +: 5] == bus.decode_rs1) begin
          val1  = bus.fwd_val[k*XLEN +: XLEN];
          pend1 = bus.fwd_pending[k];
        end
        if (bus.fwd_reg[k*5 +: 5] == bus.decode_rs2) begin
          val2  = bus.fwd_val[k*XLEN +: XLEN];
          pend2 = bus.fwd_pending[k];
        end
      end
    end
    if (bus.decode_rs1 == 5'd0) begin
      val1  = '0;
      pend1 = 1'b0;
    end
    if (bus.decode_rs2 == 5'd0) begin
      val2  = '0;
      pend2 = 1'b0;
    end
  end

  // Only operands the opcode actually reads may raise a load-use hazard.
  always_comb begin
    use1 = !((bus.decode_opcode == OPC_LUI) || (bus.decode_opcode == OPC_AUIPC) ||
             (bus.decode_opcode == OPC_JAL));
    use2 = (bus.decode_opcode == OPC_OP) || (bus.decode_opcode == OPC_STORE) ||
           (bus.decode_opcode == OPC_BRANCH);
    hazard       = (use1 && pend1) || (use2 && pend2);
    hazard_stall = bus.decode_valid && hazard && !bus.i_pipe_flush && !i_reset;
  end

  assign bus.o_hazard_stall = hazard_stall;

  // rr pipeline register: reset > flush > downstream stall > bubble > capture.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      bus.rr_valid     <= 1'b0;
      bus.rr_pc        <= '0;
      bus.rr_inst      <= INST_NOP;
      bus.rr_imm32     <= '0;
      bus.rr_opcode    <= OPC_NOP;
      bus.rr_funct3    <= '0;
      bus.rr_funct7    <= '0;
      bus.rr_rd        <= '0;
      bus.rr_rs1       <= '0;
      bus.rr_rs2       <= '0;
      bus.o_hazard_cnt <= '0;
    end else if (bus.i_pipe_flush) begin
      bus.rr_valid  <= 1'b0;
      bus.rr_inst   <= INST_NOP;
      bus.rr_opcode <= OPC_NOP;
      bus.rr_rd     <= '0;
    end else if (bus.i_pipe_stall) begin
      bus.rr_valid <= bus.rr_valid;
    end else if (hazard_stall) begin
      bus.rr_valid  <= 1'b0;
      bus.rr_inst   <= INST_NOP;
      bus.rr_opcode <= OPC_NOP;
      bus.rr_rd     <= '0;
      if (!(&bus.o_hazard_cnt)) begin
        bus.o_hazard_cnt <= bus.o_hazard_cnt + 1'b1;
      end
    end else begin
      bus.rr_valid  <= bus.decode_valid;
      bus.rr_pc     <= bus.decode_pc;
      bus.rr_inst   <= bus.decode_inst;
      bus.rr_imm32  <= bus.decode_imm32;
      bus.rr_opcode <= bus.decode_opcode;
      bus.rr_funct3 <= bus.decode_funct3;
      bus.rr_funct7 <= bus.decode_funct7;
      bus.rr_rd     <= bus.decode_rd;
      bus.rr_rs1    <= val1;
      bus.rr_rs2    <= val2;
    end
  end
endmodule
